maze_loader: RTL and testbench
==============================

Name: maze_loader

Overview:
- Upstream stage of the rat-in-maze solver. It loads a 16x16 maze bitmap, one row per handshake, into the maze memory.
- It checks that the entry cell (0,0) and the exit cell (15,15) are free, then issues a one-cycle start pulse to the solver.
- It drives the maze memory write port only while loading. The solver owns that port at all other times, and the top level muxes on busy.

Parameters:
- ROWS, 16, number of maze rows; loc row field = loc[7:4]
- COLS, 16, number of maze columns and row_data width; loc column field = loc[3:0]
- LOC_W, 8, maze memory address width; must equal log2(ROWS)+log2(COLS)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- load_req  input  1  level; sampled in IDLE or DONE or ERR to begin a new load
- row_valid  input  1  upstream row available
- row_data  input  COLS  row bits; row_data[c] = column c; 1 = wall, 0 = free
- row_ready  output  1  loader can accept a row this cycle
- mem_wr  output  1  write strobe to maze memory
- mem_loc  output  LOC_W  write address = {row, col}
- mem_dIn  output  1  cell value written
- start  output  1  one-cycle pulse to the solver's start input
- busy  output  1  loader owns the memory port
- loaded  output  1  maze loaded and valid; held until next load_req
- err  output  1  entry or exit cell is a wall; held until next load_req

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE and all outputs 0. The row and column counters and the captured row register are cleared. Reset mid-load abandons the load; partially written memory is not cleaned up.
- States: IDLE, WAIT_ROW, WRITE, CHECK, START, DONE, ERR.
- IDLE, DONE, ERR:
  - load_req=1 goes to WAIT_ROW next cycle.
  - loaded and err clear on that transition.
  - row=0, col=0.
- WAIT_ROW:
  - row_ready=1, busy=1.
  - On row_valid && row_ready the loader captures row_data into its row register and goes to WRITE.
  - row_ready is 0 in every other state.
- WRITE:
  - busy=1, mem_wr=1, mem_loc={row,col}, mem_dIn=rowreg[col].
  - One cell per cycle, col 0..COLS-1, so a row takes exactly COLS cycles.
  - On col=COLS-1, col wraps to 0.
  - If row=ROWS-1 the next state is CHECK. Otherwise row increments and the next state is WAIT_ROW.
- Entry and exit capture:
  - Cell (0,0) value is latched during its write.
  - Cell (ROWS-1,COLS-1) value is latched during its write.
- CHECK (1 cycle, busy=1, no writes):
  - If either latched value is 1, go to ERR.
  - Otherwise go to START.
- START (1 cycle): start=1, busy=0, then go to DONE.
- DONE: loaded=1 and start=0.
- ERR: err=1 and start is never pulsed.
- load_req is ignored in WAIT_ROW, WRITE, CHECK and START.
- row_valid outside WAIT_ROW is ignored and no row is consumed.
- Total latency for a good maze: ROWS handshakes + ROWS*COLS write cycles + CHECK + START. With a zero-wait source that is 16*(1+16)+2 = 274 cycles from the first WAIT_ROW cycle to the start pulse.
- Row and column counters are unsigned. There is no overflow beyond ROWS-1 or COLS-1 because the FSM exits first.

Optional Feature:
- Macro: MAZE_LOADER_WALLCNT_EN.
- With the macro defined:
  - Adds output wall_cnt, width LOC_W+1.
  - Cleared on reset and on load_req acceptance.
  - Increments on each WRITE cycle with mem_dIn=1.
  - Stable from CHECK onward.
- Without the macro: the port and its counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset with outputs driven: assert rst=0 mid-WRITE at row 5 -> all outputs 0 immediately; after release the state is IDLE and row_ready=0.
- All-zero maze, row_valid always 1, load_req pulse -> exactly 256 mem_wr cycles with mem_loc 0x00..0xFF in order and mem_dIn=0. start pulses once, 274 cycles after entering WAIT_ROW; loaded=1 and err=0.
- Border walls except entry and exit (row 0 = 16'hFFFE, row 15 = 16'h7FFF, middle rows = 16'h8001) -> loc 0x01=1, loc 0x00=0, loc 0xFF=0, start pulses. With MAZE_LOADER_WALLCNT_EN: wall_cnt=15+15+14*2=58.
- Exit blocked (row 15 = 16'h8000) -> err=1, start never asserts, loaded=0. A following load_req clears err and reloads.
- Stalling source: row_valid toggles 1,0,0,1 per row -> row_ready is high only in WAIT_ROW, no row is skipped or duplicated, and memory contents match the stimulus.
- load_req held high during loading and row_valid high during WRITE -> neither restarts the load nor consumes an extra row; after DONE, a held load_req starts a new load on the next cycle.

Source files
------------

// File: rtl/maze_loader.sv
// maze_loader: loads a ROWS x COLS maze bitmap, one row per handshake, into
// the maze memory. After the last cell it checks that the entry (0,0) and the
// exit (ROWS-1,COLS-1) are free. If both are free it pulses start to the
// solver, otherwise it raises err.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   load_req              level; accepted in IDLE/DONE/ERR to begin a load
//   row_valid, row_data   upstream row; row_data[c] is column c, 1 = wall
//   row_ready             a row is accepted this cycle (WAIT_ROW only)
//   mem_wr, mem_loc,      maze memory write port, mem_loc = {row, col};
//   mem_dIn               driven only while busy
//   start                 one-cycle pulse to the solver
//   busy                  loader owns the memory port
//   loaded, err           result flags, held until the next accepted load_req
//   wall_cnt              (MAZE_LOADER_WALLCNT_EN only) count of wall cells
//
// Optional feature: define MAZE_LOADER_WALLCNT_EN to add the wall_cnt output.
module maze_loader #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int LOC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    input  logic             row_valid,
    input  logic [COLS-1:0]  row_data,
    output logic             row_ready,
    output logic             mem_wr,
    output logic [LOC_W-1:0] mem_loc,
    output logic             mem_dIn,
    output logic             start,
    output logic             busy,
    output logic             loaded,
    output logic             err
`ifdef MAZE_LOADER_WALLCNT_EN
    ,
    output logic [LOC_W:0]   wall_cnt
`endif
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic [2:0] {
        IDLE, WAIT_ROW, WRITE, CHECK, START, DONE, ERR
    } state_t;

    state_t          state, nxt;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [COLS-1:0] rowreg;
    logic            entry_wall, exit_wall;
    logic            last_col, last_row, accept;

    assign last_col = (col == CW'(COLS - 1));
    assign last_row = (row == RW'(ROWS - 1));
    // A new load is only accepted from one of the resting states.
    assign accept   = load_req && (state == IDLE || state == DONE || state == ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            rowreg     <= '0;
            entry_wall <= 1'b0;
            exit_wall  <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                IDLE, DONE, ERR: begin
                    row <= '0;
                    col <= '0;
                end
                WAIT_ROW: if (row_valid) rowreg <= row_data;
                WRITE: begin
                    col <= last_col ? '0 : col + 1'b1;
                    // Row only advances when another row is still to come,
                    // so the counter never runs past ROWS-1.
                    if (last_col && !last_row) row <= row + 1'b1;
                    if (row == '0 && col == '0) entry_wall <= rowreg[col];
                    if (last_row && last_col)   exit_wall  <= rowreg[col];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nxt       = state;
        row_ready = 1'b0;
        mem_wr    = 1'b0;
        mem_loc   = '0;
        mem_dIn   = 1'b0;
        start     = 1'b0;
        busy      = 1'b0;
        loaded    = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE:  if (load_req) nxt = WAIT_ROW;
            DONE: begin
                loaded = 1'b1;
                if (load_req) nxt = WAIT_ROW;
            end
            ERR: begin
                err = 1'b1;
                if (load_req) nxt = WAIT_ROW;
            end
            WAIT_ROW: begin
                row_ready = 1'b1;
                busy      = 1'b1;
                if (row_valid) nxt = WRITE;
            end
            WRITE: begin
                busy    = 1'b1;
                mem_wr  = 1'b1;
                mem_loc = {row, col};
                mem_dIn = rowreg[col];
                if (last_col) nxt = last_row ? CHECK : WAIT_ROW;
            end
            CHECK: begin
                busy = 1'b1;
                nxt  = (entry_wall || exit_wall) ? ERR : START;
            end
            START: begin
                start = 1'b1;
                nxt   = DONE;
            end
            default: nxt = IDLE;
        endcase
    end

`ifdef MAZE_LOADER_WALLCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          wall_cnt <= '0;
        else if (accept)                   wall_cnt <= '0;
        else if (state == WRITE && mem_dIn) wall_cnt <= wall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_maze_loader.sv
module tb_maze_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_req = 1'b0;
    logic        row_valid = 1'b0;
    logic [15:0] row_data = '0;
    logic        row_ready, mem_wr, mem_dIn, start, busy, loaded, err;
    logic [7:0]  mem_loc;
`ifdef MAZE_LOADER_WALLCNT_EN
    logic [8:0]  wall_cnt;
`endif

    maze_loader dut (
        .clk(clk), .rst(rst), .load_req(load_req), .row_valid(row_valid),
        .row_data(row_data), .row_ready(row_ready), .mem_wr(mem_wr),
        .mem_loc(mem_loc), .mem_dIn(mem_dIn), .start(start), .busy(busy),
        .loaded(loaded), .err(err)
`ifdef MAZE_LOADER_WALLCNT_EN
        , .wall_cnt(wall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] maze [16];
    logic        tbmem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int popcount_maze();
        int n = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) n += int'(maze[r][c]);
        return n;
    endfunction

    function automatic void random_maze(input bit free_ends);
        for (int r = 0; r < 16; r++) maze[r] = 16'($urandom);
        if (free_ends) begin
            maze[0][0]   = 1'b0;
            maze[15][15] = 1'b0;
        end
    endfunction

    // vmode: 0 = row_valid always 1, 1 = pattern 1,0,0,1, 2 = random.
    // The expected stream is the maze in raster order; the expected result is
    // err if either corner is a wall, otherwise one start and loaded.
    task automatic run_load(input int vmode, input bit hold, input bit check_lat);
        int   hs = 0, wr = 0, cyc = 0, first_rr = -1, start_cyc = -1, starts = 0, bad = 0;
        bit   done = 0, rr, rv;
        logic ee;
        ee = maze[0][0] | maze[15][15];
        for (int i = 0; i < 256; i++) tbmem[i] = 1'bx;
        load_req = 1'b1;
        while (!done && cyc < 3000) begin
            case (vmode)
                0:       rv = 1'b1;
                1:       rv = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rv = 1'($urandom_range(0, 1));
            endcase
            row_valid = rv;
            row_data  = (rv && hs < 16) ? maze[hs] : 16'($urandom);
            rr = row_ready;
            tick();
            cyc++;
            if (!hold) load_req = 1'b0;
            if (rr && rv) hs++;
            if (cyc == 1) chk("flags_clear", {loaded, err}, 2'b00);
            if (row_ready) begin
                if (first_rr < 0) first_rr = cyc;
                chk("rdy_excl", {mem_wr, start, busy}, 3'b001);
            end
            if (mem_wr) begin
                chk("wr_loc", mem_loc, wr[7:0]);
                chk("wr_dat", mem_dIn, maze[wr / 16][wr % 16]);
                tbmem[mem_loc] = mem_dIn;
                wr++;
            end
            if (start) begin
                starts++;
                start_cyc = cyc;
                chk("start_busy", busy, 0);
            end
            if (loaded || err) done = 1;
        end
        chk("timeout", done, 1);
        chk("rows", hs, 16);
        chk("writes", wr, 256);
        chk("starts", starts, !ee);
        chk("loaded", loaded, !ee);
        chk("err", err, ee);
        // Cycles counted inclusively from the first WAIT_ROW cycle to START.
        if (check_lat && !ee) chk("latency", start_cyc - first_rr + 1, 274);
        for (int i = 0; i < 256; i++) if (tbmem[i] !== maze[i / 16][i % 16]) bad++;
        chk("mem", bad, 0);
`ifdef MAZE_LOADER_WALLCNT_EN
        chk("wall_cnt", wall_cnt, popcount_maze());
`endif
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_out", {row_ready, mem_wr, mem_loc, mem_dIn, start, busy, loaded, err}, 0);
        rst = 1'b1;
        tick();
        chk("idle_out", {row_ready, mem_wr, mem_loc, mem_dIn, start, busy, loaded, err}, 0);

        // All-zero maze, zero-wait source, latency
        for (int r = 0; r < 16; r++) maze[r] = 16'h0000;
        run_load(0, 0, 1);
        tick();

        // Border walls, entry and exit open
        maze[0]  = 16'hFFFE;
        maze[15] = 16'h7FFF;
        for (int r = 1; r < 15; r++) maze[r] = 16'h8001;
        run_load(0, 0, 1);
        chk("loc01", tbmem[1], 1);
        chk("loc00", tbmem[0], 0);
        chk("locFF", tbmem[255], 0);
`ifdef MAZE_LOADER_WALLCNT_EN
        chk("wall58", wall_cnt, 58);
`endif

        // Exit blocked, then a reload clears err
        random_maze(1);
        maze[15] = 16'h8000;
        run_load(2, 0, 0);
        tick();
        chk("err_held", {err, loaded, start}, 3'b100);
        random_maze(1);
        run_load(0, 0, 1);

        // Stalling source 1,0,0,1
        random_maze(1);
        run_load(1, 0, 0);

        // load_req held through the load; restarts right after DONE
        random_maze(1);
        run_load(0, 1, 0);
        tick();
        chk("held_restart", {row_ready, loaded}, 2'b10);
        random_maze(1);
        run_load(2, 0, 0);

        // Random mazes with random corners and random stalls
        for (int k = 0; k < 4; k++) begin
            random_maze(0);
            run_load(2, 0, 0);
        end

        // Reset in the middle of row 5
        random_maze(1);
        load_req  = 1'b1;
        row_valid = 1'b1;
        begin
            int  n = 0;
            int  ri = 0;
            bit  hit = 0;
            while (!hit && n < 2000) begin
                row_data = maze[ri % 16];
                if (row_ready) ri++;
                tick();
                n++;
                load_req = 1'b0;
                if (mem_wr && mem_loc[7:4] == 4'd5) hit = 1;
            end
            chk("reach_row5", hit, 1);
        end
        rst = 1'b0;
        #1;
        chk("async_rst", {row_ready, mem_wr, mem_loc, mem_dIn, start, busy, loaded, err}, 0);
`ifdef MAZE_LOADER_WALLCNT_EN
        chk("rst_wcnt", wall_cnt, 0);
`endif
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("post_rst", {row_ready, mem_wr, busy, start}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
